vga_vram_arbiter: RTL and testbench
===================================

Name: vga_vram_arbiter

Overview:
- Shares one single-port, synchronous-read character/pixel RAM between three requesters.
- Requester 1: VGA scanout read path, driven by the picture generator.
- Requester 2: calculator write port, which pushes stack contents into screen cells.
- Requester 3: an internal screen-clear sequencer.
- Scanout owns the RAM during the active display area. Writes and the clear sequencer share blanking time by round-robin.

Parameters:
- CELLS, 2400, number of addressable screen cells (80x30 text grid).
- ADDR_W, 12, RAM address width; must satisfy 2^ADDR_W >= CELLS.
- DATA_W, 8, cell data width.
- CLEAR_VALUE, 8'h20, value written by the clear sequencer (ASCII space).

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-low reset
- in_display_area  in  1  high during visible pixels, from VGA_sync
- scan_rd_req  in  1  scanout read request, one per cycle allowed
- scan_addr  in  ADDR_W  scanout cell address
- scan_data  out  DATA_W  read data returned to scanout
- scan_valid  out  1  scan_data valid strobe
- wr_req  in  1  calculator write request, level, held until ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse: write accepted
- wr_err  out  1  one-cycle pulse with wr_ack when wr_addr >= CELLS
- clear_start  in  1  pulse: begin full-screen clear
- clear_busy  out  1  high while clear in progress
- clear_done  out  1  one-cycle pulse after last cell written
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_addr

Behaviour:
- Reset values (reset low, asynchronous): all outputs 0.
  - Clear FSM returns to CLR_IDLE.
  - Clear address counter and round-robin pointer are cleared.
  - A clear in progress is aborted with no clear_done; partial writes stay in RAM.
- Priority per cycle, evaluated in this order:
  - (1) scan_rd_req=1: drive a scan read. Allowed in any cycle, but required only when in_display_area=1.
  - (2) in_display_area=0 and a write source is pending: perform one write.
  - (3) otherwise: mem_we=0, mem_addr holds its last value.
- While in_display_area=1, no write is ever issued, even if scan_rd_req=0.
- Scan latency:
  - Request in cycle N; mem_addr is registered in N+1; RAM data returns in N+2.
  - scan_valid=1 and scan_data=mem_rdata in cycle N+2.
  - Fully pipelined: back-to-back requests produce back-to-back valids.
- Write handshake:
  - When wr_req wins, wr_ack pulses in that cycle. mem_we/addr/wdata are registered for the next cycle.
  - The requester may drop or change wr_req/addr/data in the cycle after the ack.
  - If wr_addr >= CELLS: wr_ack and wr_err pulse together, and mem_we stays 0.
- Clear FSM states:
  - CLR_IDLE: clear_start=1 -> CLR_RUN, clr_addr=0, clear_busy=1.
  - CLR_RUN: on each write grant, write CLEAR_VALUE at clr_addr, then clr_addr+1. After the grant at clr_addr=CELLS-1 -> CLR_DONE.
  - CLR_DONE: clear_done=1 for one cycle, clear_busy=0 -> CLR_IDLE.
  - clear_start while in CLR_RUN or CLR_DONE is ignored.
- Round-robin:
  - When both wr_req and the clear sequencer are pending in the same grant cycle, the source not granted last wins.
  - The pointer updates only on contested grants.
  - The first contested grant after reset goes to wr_req.
- Uncontested: the sole pending source wins. A pending source never waits more than 1 grant cycle behind the other.
- Address counter: ADDR_W bits, stops at CELLS-1, no wrap.

Optional Feature:
- Macro VRAM_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles with wr_req=1 and wr_ack=0; saturates at 16'hFFFF.
  - Cleared by reset or by clear_start accepted in CLR_IDLE.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Scan read 0x005 with RAM[5]=0x41, in_display_area=1 -> scan_valid=1 and scan_data=0x41 exactly 2 cycles later; 4 consecutive reads -> 4 consecutive valids.
- wr_req addr 0x010 data 0x33 held while in_display_area=1 for 10 cycles -> no mem_we. Then in_display_area=0 -> wr_ack on the first blanking cycle, and mem_we=1, addr 0x010, wdata 0x33 the next cycle.
- wr_req addr 2400 (=CELLS) in blanking -> wr_ack=1 and wr_err=1 same cycle; mem_we stays 0.
- clear_start with CELLS=8 override, blanking held -> 8 writes of 0x20 to addresses 0..7; clear_done pulses once; clear_busy falls with clear_done; a second clear_start mid-run is ignored.
- Clear running and wr_req held continuously during blanking -> grants alternate: wr first, then clear, wr, clear…; wr_ack for each new wr_req arrives within 2 grant cycles.
- reset asserted mid-clear at clr_addr=3 -> all outputs 0 immediately, clear_busy=0, no clear_done. With VRAM_STALL_CNT_EN: stall_cnt reads 0 after reset and increments by exactly 10 during a 10-cycle display-area stall.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// Shared VRAM port arbiter: scanout reads, calculator writes and a screen-clear sequencer.
// Define VRAM_STALL_CNT_EN to add the stall_cnt output (write-request stall cycle counter).
//
// state    | meaning
// CLR_IDLE | no clear in progress, clear_start accepted
// CLR_RUN  | sequencer competes for blanking write slots, one cell per grant
// CLR_DONE | last cell granted, clear_done pulses for this one cycle
module vga_vram_arbiter #(
   parameter int                CELLS       = 2400,
   parameter int                ADDR_W      = 12,
   parameter int                DATA_W      = 8,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_display_area,
   input  logic              scan_rd_req,
   input  logic [ADDR_W-1:0] scan_addr,
   output logic [DATA_W-1:0] scan_data,
   output logic              scan_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef VRAM_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W:0]   CELLS_X   = (ADDR_W+1)'(CELLS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

   typedef enum logic [1:0] {
      CLR_IDLE = 2'd0,
      CLR_RUN  = 2'd1,
      CLR_DONE = 2'd2
   } clr_state_t;

   clr_state_t        clr_state_q;
   logic [ADDR_W-1:0] clr_addr_q;
   logic              clear_busy_q;
   logic              clear_done_q;

   logic              run_q, run_d;
   logic              rr_wr_last_q, rr_wr_last_d;
   logic              rd_p1_q, rd_p1_d;
   logic              scan_valid_q, scan_valid_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic clr_pend, slot, contested, gnt_wr, gnt_clr, wr_bad, scan_go, clr_accept;

   // run_q keeps every grant and handshake output quiet until the first edge after reset
   always_comb begin
      clr_pend   = (clr_state_q == CLR_RUN);
      scan_go    = run_q && scan_rd_req;
      slot       = run_q && !scan_rd_req && !in_display_area && (wr_req || clr_pend);
      contested  = slot && wr_req && clr_pend;
      gnt_wr     = slot && wr_req && (!clr_pend || !rr_wr_last_q);
      gnt_clr    = slot && clr_pend && !gnt_wr;
      wr_bad     = ({1'b0, wr_addr} >= CELLS_X);
      clr_accept = (clr_state_q == CLR_IDLE) && clear_start;
   end

   always_comb begin
      run_d        = 1'b1;
      rd_p1_d      = scan_go;
      scan_valid_d = rd_p1_q;
      rr_wr_last_d = contested ? gnt_wr : rr_wr_last_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if (scan_go) begin
         mem_addr_d = scan_addr;
      end else if (gnt_wr && !wr_bad) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = wr_addr;
         mem_wdata_d = wr_data;
      end else if (gnt_clr) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = clr_addr_q;
         mem_wdata_d = CLEAR_VALUE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q        <= 1'b0;
         rd_p1_q      <= 1'b0;
         scan_valid_q <= 1'b0;
         rr_wr_last_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         run_q        <= run_d;
         rd_p1_q      <= rd_p1_d;
         scan_valid_q <= scan_valid_d;
         rr_wr_last_q <= rr_wr_last_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_state_q  <= CLR_IDLE;
         clr_addr_q   <= '0;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         case (clr_state_q)
            CLR_IDLE: begin
               clear_done_q <= 1'b0;
               if (clr_accept) begin
                  clr_state_q  <= CLR_RUN;
                  clr_addr_q   <= '0;
                  clear_busy_q <= 1'b1;
               end
            end
            CLR_RUN: begin
               if (gnt_clr) begin
                  if (clr_addr_q == LAST_ADDR) begin
                     clr_state_q  <= CLR_DONE;
                     clear_busy_q <= 1'b0;
                     clear_done_q <= 1'b1;
                  end else begin
                     clr_addr_q <= clr_addr_q + ADDR_W'(1);
                  end
               end
            end
            CLR_DONE: begin
               clr_state_q  <= CLR_IDLE;
               clear_done_q <= 1'b0;
            end
            default: begin
               clr_state_q  <= CLR_IDLE;
               clear_busy_q <= 1'b0;
               clear_done_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef VRAM_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (clr_accept) begin
         stall_d = '0;
      end else if (wr_req && !gnt_wr && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

   assign wr_ack     = gnt_wr;
   assign wr_err     = gnt_wr && wr_bad;
   assign scan_valid = scan_valid_q;
   assign scan_data  = scan_valid_q ? mem_rdata : '0;
   assign clear_busy = clear_busy_q;
   assign clear_done = clear_done_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter with an 8-cell screen, a behavioural RAM and a reference model.
// Define VRAM_STALL_CNT_EN to also check the stall counter.
module tb_vga_vram_arbiter;
   localparam int CELLS  = 8;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_display_area, scan_rd_req, wr_req, clear_start;
   logic [ADDR_W-1:0] scan_addr, wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] scan_data, mem_wdata, mem_rdata;
   logic              scan_valid, wr_ack, wr_err, clear_busy, clear_done, mem_we;
   logic [ADDR_W-1:0] mem_addr;
`ifdef VRAM_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   always #5 clk = ~clk;

   vga_vram_arbiter #(.CELLS(CELLS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_VALUE(8'h20)) dut (
      .clk(clk), .reset(reset), .in_display_area(in_display_area),
      .scan_rd_req(scan_rd_req), .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
      .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
`ifdef VRAM_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .mem_rdata(mem_rdata));

   // single-port synchronous RAM, read-first
   logic [7:0] ram [0:4095];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // reference model: what the RAM bus, scan return and clear sequencer should look like
   logic [7:0]  ref_mem [0:4095];
   bit          m_we, m_rd, m_valid, m_busy, m_done, m_wr_turn;
   logic [11:0] m_addr;
   logic [7:0]  m_wdata, m_data;
   int          m_clr_next, m_stall;
   bit          last_ack;
   int          n_vec = 0, n_err = 0;
   int          obs_clr_wr, obs_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_we = 0; m_rd = 0; m_valid = 0; m_busy = 0; m_done = 0; m_wr_turn = 1;
      m_addr = '0; m_wdata = '0; m_data = '0; m_clr_next = 0; m_stall = 0; last_ack = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".scan_valid"}, 32'(scan_valid), 0);
      check({tag, ".scan_data"},  32'(scan_data),  0);
      check({tag, ".wr_ack"},     32'(wr_ack),     0);
      check({tag, ".wr_err"},     32'(wr_err),     0);
      check({tag, ".clear_busy"}, 32'(clear_busy), 0);
      check({tag, ".clear_done"}, 32'(clear_done), 0);
      check({tag, ".mem_we"},     32'(mem_we),     0);
      check({tag, ".mem_addr"},   32'(mem_addr),   0);
      check({tag, ".mem_wdata"},  32'(mem_wdata),  0);
`ifdef VRAM_STALL_CNT_EN
      check({tag, ".stall_cnt"},  32'(stall_cnt),  0);
`endif
   endtask

   // called at posedge+1 with inputs applied; checks at negedge, then advances the model
   task automatic tick();
      bit slot, g_wr, g_clr, bad, acc, n_done;
      slot  = !scan_rd_req && !in_display_area && (wr_req || m_busy);
      g_wr  = 0;
      g_clr = 0;
      if (slot) begin
         if (wr_req && m_busy) begin
            g_wr      = m_wr_turn;
            g_clr     = !m_wr_turn;
            m_wr_turn = !m_wr_turn;
         end else begin
            g_wr  = wr_req;
            g_clr = !wr_req;
         end
      end
      bad = (int'(wr_addr) >= CELLS);
      @(negedge clk);
      check("scan_valid", 32'(scan_valid), 32'(m_valid));
      if (m_valid) check("scan_data", 32'(scan_data), 32'(m_data));
      check("wr_ack",     32'(wr_ack),     32'(g_wr));
      check("wr_err",     32'(wr_err),     32'(g_wr && bad));
      check("mem_we",     32'(mem_we),     32'(m_we));
      check("mem_addr",   32'(mem_addr),   32'(m_addr));
      check("mem_wdata",  32'(mem_wdata),  32'(m_wdata));
      check("clear_busy", 32'(clear_busy), 32'(m_busy));
      check("clear_done", 32'(clear_done), 32'(m_done));
`ifdef VRAM_STALL_CNT_EN
      check("stall_cnt",  32'(stall_cnt),  32'(m_stall));
`endif
      if (mem_we === 1'b1 && mem_wdata === 8'h20) obs_clr_wr++;
      if (clear_done === 1'b1) obs_done++;
      // RAM sees the bus: a read this cycle returns data next cycle, a write lands at the edge
      m_valid = m_rd;
      m_data  = ref_mem[m_addr];
      if (m_we) ref_mem[m_addr] = m_wdata;
      m_rd = 0;
      m_we = 0;
      if (scan_rd_req) begin
         m_rd = 1; m_addr = scan_addr;
      end else if (g_wr && !bad) begin
         m_we = 1; m_addr = wr_addr; m_wdata = wr_data;
      end else if (g_clr) begin
         m_we = 1; m_addr = 12'(m_clr_next); m_wdata = 8'h20;
      end
      acc    = clear_start && !m_busy && !m_done;
      n_done = 0;
      if (g_clr) begin
         if (m_clr_next == CELLS - 1) begin
            m_busy = 0; n_done = 1;
         end else begin
            m_clr_next++;
         end
      end
      m_done = n_done;
      if (acc) begin
         m_busy = 1; m_clr_next = 0; m_stall = 0;
      end else if (wr_req && !g_wr && m_stall < 65535) begin
         m_stall++;
      end
      last_ack = g_wr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_display_area = 0; scan_rd_req = 0; scan_addr = '0;
      wr_req = 0; wr_addr = '0; wr_data = '0; clear_start = 0;
   endtask

   initial begin
      int v, stall0, guard;
      for (int i = 0; i < 4096; i++) begin
         v = int'($urandom_range(0, 255));
         ram[i] = 8'(v);
         ref_mem[i] = 8'(v);
      end
      ram[5] = 8'h41;
      ref_mem[5] = 8'h41;
      idle_inputs();
      model_reset();
      reset = 1;
      #1 reset = 0;
      #2 check_zero("reset");
      @(posedge clk);
      #1 reset = 1;
      tick();
      tick();

      // scan read of cell 5 during display, then four back-to-back reads
      in_display_area = 1; scan_rd_req = 1; scan_addr = 12'h005;
      tick();
      scan_rd_req = 0;
      tick(); tick(); tick();
      for (int i = 0; i < 4; i++) begin
         scan_rd_req = 1; scan_addr = 12'(4 + i);
         tick();
      end
      scan_rd_req = 0;
      tick(); tick(); tick();

      // write held through 10 display cycles, then accepted on the first blanking cycle
      wr_req = 1; wr_addr = 12'h006; wr_data = 8'h33;
`ifdef VRAM_STALL_CNT_EN
      stall0 = int'(stall_cnt);
`endif
      for (int i = 0; i < 10; i++) tick();
`ifdef VRAM_STALL_CNT_EN
      check("stall_plus_10", 32'(stall_cnt), 32'(stall0 + 10));
`endif
      in_display_area = 0;
      tick();
      wr_req = 0;
      tick();

      // address boundaries: last cell, first out-of-range, full-size screen edge
      wr_req = 1; wr_addr = 12'(CELLS - 1); wr_data = 8'h5A; tick();
      wr_addr = 12'(CELLS);   wr_data = 8'h77; tick();
      wr_addr = 12'd2400;     wr_data = 8'h78; tick();
      wr_req = 0; tick(); tick();

      // full clear with a second clear_start mid-run
      obs_clr_wr = 0; obs_done = 0;
      clear_start = 1; tick();
      clear_start = 0; tick(); tick(); tick();
      clear_start = 1; tick();
      clear_start = 0;
      for (int i = 0; i < 9; i++) tick();
      check("clear_writes", 32'(obs_clr_wr), 32'(CELLS));
      check("clear_done_pulses", 32'(obs_done), 1);
      for (int i = 0; i < CELLS; i++) check("ram_cleared", 32'(ram[i]), 32'h20);

      // clear contested by a continuously held write request
      clear_start = 1; tick();
      clear_start = 0;
      wr_req = 1; wr_addr = 12'($urandom_range(0, CELLS - 1)); wr_data = 8'($urandom);
      for (int i = 0; i < 2 * CELLS + 4; i++) begin
         tick();
         if (last_ack) begin
            wr_addr = 12'($urandom_range(0, CELLS - 1)); wr_data = 8'($urandom);
         end
      end
      wr_req = 0; tick(); tick();

      // reset in the middle of a clear, with the sequencer at cell 3
      clear_start = 1; tick();
      clear_start = 0;
      guard = 0;
      while (m_clr_next != 3 && guard < 20) begin
         tick();
         guard++;
      end
      check("reach_clr_addr_3", 32'(m_clr_next), 3);
      #2 reset = 0;
      #1 check_zero("mid_clear_reset");
      model_reset();
      @(posedge clk);
      #1 check_zero("held_reset");
      reset = 1;
      tick();
      tick();

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) in_display_area = !in_display_area;
         scan_rd_req = ($urandom_range(0, 2) == 0);
         scan_addr   = 12'($urandom_range(0, 15));
         if (!wr_req || last_ack) begin
            wr_req  = ($urandom_range(0, 1) == 1);
            wr_addr = 12'($urandom_range(0, CELLS + 1));
            wr_data = 8'($urandom);
         end
         clear_start = ($urandom_range(0, 24) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
